// File: rtl/window_generator.sv
// KxK sliding-window generator over a raster pixel stream, with stride, channel count and frame-last flag.
// Window, out_valid and out_last are registered one cycle after the accepted pixel; all state holds when data_in_valid=0.
module window_generator #(
   parameter int KERNEL_SIZE = 3,
   parameter int DATA_WIDTH  = 16,
   parameter int CHANNELS    = 1,
   parameter int ROW_SIZE    = 5,
   parameter int COLUMN_SIZE = 5,
   parameter int STRIDE      = 1
) (
   input  logic                                                   clock,
   input  logic                                                   sreset_n,
   input  logic                                                   data_in_valid,
   input  logic [CHANNELS*DATA_WIDTH-1:0]                         data_in,
   output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] kernel_out,
   output logic                                                   out_valid,
   output logic                                                   out_last
);
   localparam int K  = KERNEL_SIZE;
   localparam int PW = CHANNELS * DATA_WIDTH;
   localparam int CW = $clog2(ROW_SIZE);
   localparam int RW = $clog2(COLUMN_SIZE);
   localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   localparam logic [CW-1:0] COL_MAX   = CW'(ROW_SIZE - 1);
   localparam logic [RW-1:0] ROW_MAX   = RW'(COLUMN_SIZE - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(K - 1 + ((ROW_SIZE - K) / STRIDE) * STRIDE);
   localparam logic [RW-1:0] ROW_LAST  = RW'(K - 1 + ((COLUMN_SIZE - K) / STRIDE) * STRIDE);
   localparam logic [SW-1:0] PH_MAX    = SW'(STRIDE - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [SW-1:0] cph_q, cph_d;
   logic [SW-1:0] rph_q, rph_d;
   logic          out_valid_q, out_last_q;
   logic          emit, last;

   logic [PW-1:0] lb_q  [K-1][ROW_SIZE];
   logic [PW-1:0] win_q [K][K];
   logic [PW-1:0] tap   [K];

   // Line buffers are addressed by column: entry j holds the pixel from j+1 rows above.
   always_ff @(posedge clock) begin
      if (sreset_n && data_in_valid) begin
         lb_q[0][col_q] <= data_in;
         for (int j = 1; j < K - 1; j++) begin
            lb_q[j][col_q] <= lb_q[j-1][col_q];
         end
      end
   end

   always_comb begin
      tap[K-1] = data_in;
      for (int r = 0; r < K - 1; r++) begin
         tap[r] = lb_q[K-2-r][col_q];
      end
   end

   always_ff @(posedge clock) begin
      if (!sreset_n) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else if (data_in_valid) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
            win_q[r][K-1] <= tap[r];
         end
      end
   end

   always_comb begin
      kernel_out = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            kernel_out[(r*K+c)*PW +: PW] = win_q[r][c];
         end
      end
   end

   // Phase counters only run once the window is fully inside the frame on that axis.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      cph_d = cph_q;
      rph_d = rph_q;
      emit  = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST) && (rph_q == '0) && (cph_q == '0);
      last  = emit && (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (data_in_valid) begin
         if (col_q == COL_MAX) begin
            col_d = '0;
            cph_d = '0;
            if (row_q == ROW_MAX) begin
               row_d = '0;
               rph_d = '0;
            end else begin
               row_d = row_q + 1'b1;
               if (row_q >= ROW_FIRST) begin
                  rph_d = (rph_q == PH_MAX) ? '0 : rph_q + 1'b1;
               end
            end
         end else begin
            col_d = col_q + 1'b1;
            if (col_q >= COL_FIRST) begin
               cph_d = (cph_q == PH_MAX) ? '0 : cph_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!sreset_n) begin
         col_q       <= '0;
         row_q       <= '0;
         cph_q       <= '0;
         rph_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         cph_q       <= cph_d;
         rph_q       <= rph_d;
         out_valid_q <= data_in_valid && emit;
         out_last_q  <= data_in_valid && last;
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule
